// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single RAM1 controller port between instruction
// fetch (IF) and the data-memory stage (DM). Each access holds the controller
// inputs for ACCESS_CYC cycles, then pulses a one-cycle acknowledge to the owner.
// Optional build macro RAM_ARB_ROUND_ROBIN_EN: alternate grants on conflicts
// instead of the default fixed DM-over-IF priority.
module ram_port_arbiter #(
   parameter int ACCESS_CYC = 3
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_ack,
   output logic [15:0] if_data,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [15:0] dm_addr,
   input  logic [15:0] dm_wdata,
   output logic        dm_ack,
   output logic [15:0] dm_rdata,
   output logic        stall_if,
   output logic        stall_dm,
   output logic [15:0] mc_address,
   output logic [15:0] mc_dataIn,
   output logic [1:0]  mc_memRead,
   output logic [1:0]  mc_memWrite,
   input  logic [15:0] mc_dataOut
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYC - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        gnt_q, gnt_d;          // 0 = IF, 1 = DM; also remembers the last grant
   logic        if_ack_q, if_ack_d;
   logic        dm_ack_q, dm_ack_d;
   logic [15:0] if_data_q, if_data_d;
   logic [15:0] dm_rdata_q, dm_rdata_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] din_q, din_d;
   logic [1:0]  rd_q, rd_d;
   logic [1:0]  wr_q, wr_d;
   logic        win_dm_s;
   logic        last_s;

   assign last_s = (cnt_q == LAST_CNT);

   // Arbitration: pick DM (1) or IF (0) among the requesters present in IDLE.
   always_comb begin
      win_dm_s = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      if (if_req && dm_req) begin
         win_dm_s = ~gnt_q;
      end else begin
         win_dm_s = dm_req;
      end
`else
      win_dm_s = dm_req;
`endif
   end

   // State register plus all registered outputs, synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         gnt_q      <= 1'b0;
         if_ack_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
         if_data_q  <= 16'd0;
         dm_rdata_q <= 16'd0;
         addr_q     <= 16'd0;
         din_q      <= 16'd0;
         rd_q       <= 2'b00;
         wr_q       <= 2'b00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gnt_q      <= gnt_d;
         if_ack_q   <= if_ack_d;
         dm_ack_q   <= dm_ack_d;
         if_data_q  <= if_data_d;
         dm_rdata_q <= dm_rdata_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
      end
   end

   // Next-state logic: IDLE -> BUSY on any request, BUSY -> DONE after the hold, DONE -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (if_req || dm_req) begin
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (last_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output/datapath next values: launch the winner's access, hold it, capture read data, ack.
   always_comb begin
      cnt_d      = cnt_q;
      gnt_d      = gnt_q;
      if_ack_d   = 1'b0;
      dm_ack_d   = 1'b0;
      if_data_d  = if_data_q;
      dm_rdata_d = dm_rdata_q;
      addr_d     = addr_q;
      din_d      = din_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = 4'd0;
            if (if_req || dm_req) begin
               gnt_d = win_dm_s;
               if (win_dm_s) begin
                  addr_d = dm_addr;
                  din_d  = dm_wdata;
                  rd_d   = dm_we ? 2'b00 : 2'b01;
                  wr_d   = dm_we ? 2'b01 : 2'b00;
               end else begin
                  addr_d = if_addr;
                  rd_d   = 2'b01;
                  wr_d   = 2'b00;
               end
            end else begin
               rd_d = 2'b00;
               wr_d = 2'b00;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q + 4'd1;
            if (last_s) begin
               rd_d     = 2'b00;
               wr_d     = 2'b00;
               if_ack_d = ~gnt_q;
               dm_ack_d = gnt_q;
               // Only reads update the owner's data register; writes leave both untouched.
               if (rd_q == 2'b01) begin
                  if (gnt_q) begin
                     dm_rdata_d = mc_dataOut;
                  end else begin
                     if_data_d = mc_dataOut;
                  end
               end else begin
                  dm_rdata_d = dm_rdata_q;
               end
            end else begin
               rd_d = rd_q;
            end
         end
         ST_DONE: cnt_d = cnt_q;
         default: cnt_d = 4'd0;
      endcase
   end

   assign if_ack      = if_ack_q;
   assign dm_ack      = dm_ack_q;
   assign if_data     = if_data_q;
   assign dm_rdata    = dm_rdata_q;
   assign mc_address  = addr_q;
   assign mc_dataIn   = din_q;
   assign mc_memRead  = rd_q;
   assign mc_memWrite = wr_q;
   assign stall_if    = if_req & ~if_ack_q;
   assign stall_dm    = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed literal checks plus randomized traffic
// checked every cycle against a queue-based transaction model.
module tb_ram_port_arbiter;

   localparam int AC = 3;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        RST;
   logic        if_req, dm_req, dm_we;
   logic [15:0] if_addr, dm_addr, dm_wdata, mc_dataOut;
   logic        if_ack, dm_ack, stall_if, stall_dm;
   logic [15:0] if_data, dm_rdata, mc_address, mc_dataIn;
   logic [1:0]  mc_memRead, mc_memWrite;

   // second instance with a 2-cycle hold
   logic        if_req2, dm_req2, dm_we2;
   logic [15:0] if_addr2, dm_addr2, dm_wdata2, mc_dataOut2;
   logic        if_ack2, dm_ack2, stall_if2, stall_dm2;
   logic [15:0] if_data2, dm_rdata2, mc_address2, mc_dataIn2;
   logic [1:0]  mc_memRead2, mc_memWrite2;

   ram_port_arbiter #(.ACCESS_CYC(AC)) u_dut (
      .CLK(CLK), .RST(RST),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .stall_if(stall_if), .stall_dm(stall_dm),
      .mc_address(mc_address), .mc_dataIn(mc_dataIn),
      .mc_memRead(mc_memRead), .mc_memWrite(mc_memWrite), .mc_dataOut(mc_dataOut)
   );

   ram_port_arbiter #(.ACCESS_CYC(2)) u_dut2 (
      .CLK(CLK), .RST(RST),
      .if_req(if_req2), .if_addr(if_addr2), .if_ack(if_ack2), .if_data(if_data2),
      .dm_req(dm_req2), .dm_we(dm_we2), .dm_addr(dm_addr2), .dm_wdata(dm_wdata2),
      .dm_ack(dm_ack2), .dm_rdata(dm_rdata2),
      .stall_if(stall_if2), .stall_dm(stall_dm2),
      .mc_address(mc_address2), .mc_dataIn(mc_dataIn2),
      .mc_memRead(mc_memRead2), .mc_memWrite(mc_memWrite2), .mc_dataOut(mc_dataOut2)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic report(input string name, input logic ok, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
      end
   endtask
   task automatic chk1(input string name, input logic act, input logic exp);
      report(name, act === exp, {15'd0, act}, {15'd0, exp});
   endtask
   task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
      report(name, act === exp, {14'd0, act}, {14'd0, exp});
   endtask
   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      report(name, act === exp, act, exp);
   endtask

   // ---------------- transaction model ----------------
   // A grant expands into a list of per-cycle steps: AC strobe cycles, one ack
   // cycle, one settling cycle. An empty list means the arbiter is idle.
   typedef struct {
      int          kind;   // 0 strobe, 1 ack, 2 settle
      logic        dm;
      logic        rd;
      logic [15:0] addr;
      logic [15:0] din;
   } step_t;

   step_t       q[$];
   step_t       s;
   logic        e_rd, e_wr, e_if_ack, e_dm_ack;
   logic [15:0] e_addr, e_din, e_if_data, e_dm_rdata;
   logic        m_last_dm, m_w;
   logic        seen_if_ack = 1'b0, seen_dm_ack = 1'b0;
   bit          chk_en = 1'b0;

   always @(negedge CLK) begin
      if (chk_en) begin
         chk2("memRead", mc_memRead, {1'b0, e_rd});
         chk2("memWrite", mc_memWrite, {1'b0, e_wr});
         chk1("if_ack", if_ack, e_if_ack);
         chk1("dm_ack", dm_ack, e_dm_ack);
         chk16("if_data", if_data, e_if_data);
         chk16("dm_rdata", dm_rdata, e_dm_rdata);
         chk1("stall_if", stall_if, if_req & ~e_if_ack);
         chk1("stall_dm", stall_dm, dm_req & ~e_dm_ack);
         if (e_rd || e_wr) chk16("mc_address", mc_address, e_addr);
         if (e_wr) chk16("mc_dataIn", mc_dataIn, e_din);
      end
      seen_if_ack = e_if_ack;
      seen_dm_ack = e_dm_ack;
      if (!RST) begin
         q.delete();
         e_rd = 1'b0; e_wr = 1'b0; e_if_ack = 1'b0; e_dm_ack = 1'b0;
         e_addr = 16'd0; e_din = 16'd0; e_if_data = 16'd0; e_dm_rdata = 16'd0;
         m_last_dm = 1'b0;
         chk_en = 1'b1;
      end else begin
         if (q.size() == 0) begin
            e_rd = 1'b0; e_wr = 1'b0; e_if_ack = 1'b0; e_dm_ack = 1'b0;
            if (if_req || dm_req) begin
               if (if_req && dm_req) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                  m_w = !m_last_dm;
`else
                  m_w = 1'b1;
`endif
               end else begin
                  m_w = dm_req;
               end
               m_last_dm = m_w;
               s.dm   = m_w;
               s.rd   = m_w ? !dm_we : 1'b1;
               s.addr = m_w ? dm_addr : if_addr;
               s.din  = dm_wdata;
               s.kind = 0;
               for (int k = 0; k < AC; k++) q.push_back(s);
               s.kind = 1; q.push_back(s);
               s.kind = 2; q.push_back(s);
            end
         end
         if (q.size() != 0) begin
            s = q.pop_front();
            e_if_ack = 1'b0; e_dm_ack = 1'b0;
            if (s.kind == 0) begin
               e_rd = s.rd; e_wr = !s.rd; e_addr = s.addr; e_din = s.din;
            end else if (s.kind == 1) begin
               e_rd = 1'b0; e_wr = 1'b0;
               if (s.rd) begin
                  if (s.dm) e_dm_rdata = mc_dataOut;
                  else      e_if_data  = mc_dataOut;
               end
               e_if_ack = !s.dm; e_dm_ack = s.dm;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b0;
      if_req = 1'b0; if_addr = 16'd0; dm_req = 1'b0; dm_we = 1'b0;
      dm_addr = 16'd0; dm_wdata = 16'd0; mc_dataOut = 16'd0;
      if_req2 = 1'b0; if_addr2 = 16'd0; dm_req2 = 1'b0; dm_we2 = 1'b0;
      dm_addr2 = 16'd0; dm_wdata2 = 16'd0; mc_dataOut2 = 16'd0;
      cyc(); cyc();
      chk2("rst_memRead", mc_memRead, 2'b00);
      chk16("rst_if_data", if_data, 16'h0000);
      chk16("rst_address", mc_address, 16'h0000);
      chk1("rst_if_ack", if_ack, 1'b0);

      // IF read on main instance, DM read on the 2-cycle instance (cycle 0)
      RST = 1'b1;
      if_req = 1'b1; if_addr = 16'h0040; mc_dataOut = 16'h1234;
      dm_req2 = 1'b1; dm_we2 = 1'b0; dm_addr2 = 16'h0123; dm_wdata2 = 16'h7777; mc_dataOut2 = 16'hA5A5;
      #1;
      chk1("t1_stall_c0", stall_if, 1'b1);
      chk1("t6_stall_c0", stall_dm2, 1'b1);
      cyc();
      chk2("t1_rd_c1", mc_memRead, 2'b01);
      chk16("t1_addr_c1", mc_address, 16'h0040);
      chk2("t6_rd_c1", mc_memRead2, 2'b01);
      chk2("t6_wr_c1", mc_memWrite2, 2'b00);
      chk16("t6_addr_c1", mc_address2, 16'h0123);
      chk16("t6_din_c1", mc_dataIn2, 16'h7777);
      cyc();
      chk2("t1_rd_c2", mc_memRead, 2'b01);
      chk2("t6_rd_c2", mc_memRead2, 2'b01);
      chk1("t6_ack_c2", dm_ack2, 1'b0);
      cyc();
      chk2("t1_rd_c3", mc_memRead, 2'b01);
      chk1("t1_stall_c3", stall_if, 1'b1);
      chk1("t6_ack_c3", dm_ack2, 1'b1);
      chk16("t6_rdata_c3", dm_rdata2, 16'hA5A5);
      chk1("t6_stall_c3", stall_dm2, 1'b0);
      cyc();
      dm_req2 = 1'b0;
      chk1("t1_ack_c4", if_ack, 1'b1);
      chk16("t1_data_c4", if_data, 16'h1234);
      chk1("t1_stall_c4", stall_if, 1'b0);
      chk1("t6_ack_c4", dm_ack2, 1'b0);
      chk1("t6_ifack_c4", if_ack2, 1'b0);
      chk16("t6_ifdata_c4", if_data2, 16'h0000);
      chk1("t6_stallif_c4", stall_if2, 1'b0);
      cyc();
      if_req = 1'b0;
      chk1("t1_ack_c5", if_ack, 1'b0);
      chk2("t1_rd_c5", mc_memRead, 2'b00);

      // DM write
      cyc();
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h8000; dm_wdata = 16'hBEEF;
      for (int c = 1; c <= 3; c++) begin
         cyc();
         chk2("t2_wr", mc_memWrite, 2'b01);
         chk2("t2_rd", mc_memRead, 2'b00);
         chk16("t2_din", mc_dataIn, 16'hBEEF);
         chk16("t2_addr", mc_address, 16'h8000);
      end
      cyc();
      chk1("t2_ack_c4", dm_ack, 1'b1);
      chk16("t2_rdata_c4", dm_rdata, 16'h0000);
      cyc();
      dm_req = 1'b0; dm_we = 1'b0;

      // reset in BUSY cycle 2, then the held request completes
      cyc();
      if_req = 1'b1; if_addr = 16'h0222; mc_dataOut = 16'h5A5A;
      cyc(); cyc();
      RST = 1'b0;
      cyc();
      RST = 1'b1;
      chk2("t4_rd_c3", mc_memRead, 2'b00);
      chk2("t4_wr_c3", mc_memWrite, 2'b00);
      chk1("t4_ack_c3", if_ack, 1'b0);
      chk16("t4_data_c3", if_data, 16'h0000);
      chk16("t4_addr_c3", mc_address, 16'h0000);
      for (int c = 4; c <= 6; c++) begin
         cyc();
         chk2("t4_rd_re", mc_memRead, 2'b01);
         chk1("t4_noack", if_ack, 1'b0);
      end
      cyc();
      chk1("t4_ack_c7", if_ack, 1'b1);
      chk16("t4_data_c7", if_data, 16'h5A5A);
      cyc();
      if_req = 1'b0;

      // simultaneous requests; last grant is IF so DM goes first in either build
      cyc();
      if_req = 1'b1; if_addr = 16'h0100; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0200;
      mc_dataOut = 16'hC0DE;
      #1;
      chk1("t3_stallif_c0", stall_if, 1'b1);
      chk1("t3_stalldm_c0", stall_dm, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         cyc();
         chk16("t3_dm_addr", mc_address, 16'h0200);
         chk1("t3_stallif", stall_if, 1'b1);
      end
      cyc();
      chk1("t3_dmack_c4", dm_ack, 1'b1);
      chk16("t3_rdata_c4", dm_rdata, 16'hC0DE);
      cyc();
      dm_req = 1'b0; mc_dataOut = 16'hD00D;
      chk1("t3_stallif_c5", stall_if, 1'b1);
      cyc();
      chk2("t3_rd_c6", mc_memRead, 2'b01);
      chk16("t3_if_addr_c6", mc_address, 16'h0100);
      cyc(); cyc();
      chk1("t3_stallif_c8", stall_if, 1'b1);
      cyc();
      chk1("t3_ifack_c9", if_ack, 1'b1);
      chk16("t3_ifdata_c9", if_data, 16'hD00D);
      chk1("t3_stallif_c9", stall_if, 1'b0);
      cyc();
      if_req = 1'b0;

      // randomized traffic checked by the model
      for (int i = 0; i < 4000; i++) begin
         cyc();
         RST = ($urandom_range(0, 149) != 0);
         mc_dataOut = 16'($urandom);
         if (if_req) begin
            if (seen_if_ack) begin
               if_req = 1'($urandom_range(0, 1)); if_addr = 16'($urandom);
            end else if ($urandom_range(0, 39) == 0) begin
               if_req = 1'b0;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = 16'($urandom);
         end
         if (dm_req) begin
            if (seen_dm_ack) begin
               dm_req = 1'($urandom_range(0, 1)); dm_we = 1'($urandom_range(0, 1));
               dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
            end else if ($urandom_range(0, 39) == 0) begin
               dm_req = 1'b0;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
            dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
         end
      end
      cyc(); cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
